// File: rtl/secure_switch_debounce_if.sv
// -----------------------------------------------------------------------------
// secure_switch_debounce_if
//
// Purpose: groups the switch-conditioning signals so they can be passed as a
// single port between the debounce stage and its environment.
//
// Signals (all NUM_SW wide except irq):
//   sw_in      raw asynchronous switch pins            (into the debouncer)
//   irq_en     per-switch interrupt enable mask        (into the debouncer)
//   chg_clr    per-switch clear for chg_sticky         (into the debouncer)
//   sw_stable  debounced, registered switch levels     (out of the debouncer)
//   sw_rise    one-cycle pulse on a 0->1 accepted edge (out of the debouncer)
//   sw_fall    one-cycle pulse on a 1->0 accepted edge (out of the debouncer)
//   chg_sticky "changed since last clear" flags        (out of the debouncer)
//   irq        OR of (chg_sticky & irq_en)             (out of the debouncer)
//
// Protocol: there is no valid/ready handshake on this bus. Every input is a
// level sampled on each rising clock edge; every output is a level or a
// single-cycle pulse that is valid for the whole cycle after the edge that
// produced it. No transfer is ever stalled.
//
// Modports:
//   master - the environment driving the raw inputs and observing results
//   slave  - the debounce block itself
// -----------------------------------------------------------------------------
interface secure_switch_debounce_if #(
    parameter int NUM_SW = 2
);
    logic [NUM_SW-1:0] sw_in;
    logic [NUM_SW-1:0] irq_en;
    logic [NUM_SW-1:0] chg_clr;
    logic [NUM_SW-1:0] sw_stable;
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;
    logic [NUM_SW-1:0] chg_sticky;
    logic              irq;

    modport master (
        output sw_in,
        output irq_en,
        output chg_clr,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  chg_sticky,
        input  irq
    );

    modport slave (
        input  sw_in,
        input  irq_en,
        input  chg_clr,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output chg_sticky,
        output irq
    );
endinterface

// File: rtl/secure_switch_debounce.sv
// -----------------------------------------------------------------------------
// secure_switch_debounce
//
// Purpose: upstream conditioning stage for the secure switch register.
// Synchronises each raw slide-switch pin through two flops, debounces it with
// a per-switch counter, and reports accepted level changes as registered
// rise/fall pulses, sticky change flags and a level interrupt.
//
// Ports:
//   s_axi_aclk    in   system clock, all logic on its rising edge
//   s_axi_areset  in   synchronous active-high reset, highest priority
//   sw_if         slave modport of secure_switch_debounce_if
//                 (sw_in/irq_en/chg_clr in; sw_stable/sw_rise/sw_fall/
//                  chg_sticky/irq out)
//
// Parameters:
//   NUM_SW          number of independently debounced switches
//   DEBOUNCE_CYCLES consecutive mismatched cycles before a level is accepted
//   CNT_WIDTH       counter width, must hold DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
module secure_switch_debounce #(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    secure_switch_debounce_if.slave  sw_if
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]    sync1_q;
    logic [NUM_SW-1:0]    sync2_q;
    logic [NUM_SW-1:0]    stable_q;
    logic [NUM_SW-1:0]    rise_q;
    logic [NUM_SW-1:0]    fall_q;
    logic [NUM_SW-1:0]    sticky_q;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_SW];

    // accept[i] is high on the cycle whose edge commits sync2[i] into
    // sw_stable[i]: the level has disagreed for DEBOUNCE_CYCLES cycles.
    logic [NUM_SW-1:0]    accept;

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            accept[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sw_if.sw_in;
            sync2_q  <= sync1_q;
            // Accepting a change flips the stable bit to the synchronised level.
            stable_q <= stable_q ^ accept;
            rise_q   <= accept & sync2_q;
            fall_q   <= accept & ~sync2_q;
            // A change on this edge wins over a simultaneous software clear.
            sticky_q <= accept | (sticky_q & ~sw_if.chg_clr);
            for (int i = 0; i < NUM_SW; i++) begin
                // Any agreeing cycle restarts the count, so bounces shorter
                // than DEBOUNCE_CYCLES never reach sw_stable.
                if ((sync2_q[i] == stable_q[i]) || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign sw_if.sw_stable  = stable_q;
    assign sw_if.sw_rise    = rise_q;
    assign sw_if.sw_fall    = fall_q;
    assign sw_if.chg_sticky = sticky_q;
    assign sw_if.irq        = |(sticky_q & sw_if.irq_en);

endmodule

// File: doc/secure_switch_debounce.md
Name: secure_switch_debounce

Overview:
- Upstream conditioning stage for the secure switch register.
- Synchronises and debounces the raw slide-switch pins.
- Drives the clean `sw_stable` bus into the AXI switch register's `sw` input.
- Also produces per-switch edge pulses, sticky change flags and a level interrupt, so secure-world software can detect switch changes without polling.

Parameters:
- NUM_SW, 2, number of switch inputs debounced independently.
- DEBOUNCE_CYCLES, 1000000, consecutive clock cycles a new level must persist before it is accepted (10 ms at 100 MHz). Must be ≥1.
- CNT_WIDTH, 20, width of each per-switch counter. Must represent DEBOUNCE_CYCLES-1.

Ports:
- s_axi_aclk  in  1  system clock; all logic on its rising edge.
- s_axi_areset  in  1  reset, synchronous, active-high.
- sw_in  in  NUM_SW  raw asynchronous switch pins.
- irq_en  in  NUM_SW  per-switch interrupt enable mask.
- chg_clr  in  NUM_SW  per-switch clear for chg_sticky, sampled each cycle.
- sw_stable  out  NUM_SW  debounced switch levels, registered.
- sw_rise  out  NUM_SW  one-cycle pulse when sw_stable[i] goes 0→1.
- sw_fall  out  NUM_SW  one-cycle pulse when sw_stable[i] goes 1→0.
- chg_sticky  out  NUM_SW  latched "changed since last clear" flags.
- irq  out  1  level interrupt, OR of (chg_sticky & irq_en).

Behaviour:
- Reset (synchronous, active-high):
  - Both synchroniser stages, sw_stable, all counters, sw_rise, sw_fall and chg_sticky clear to 0.
  - irq is therefore 0.
  - Reset has priority over every other event in the same cycle.
- Synchroniser:
  - Per bit, two flops: sync1 <= sw_in; sync2 <= sync1.
  - Only sync2 is used downstream.
- Per-switch debounce (independent for each i):
  - If sync2[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1:
    - sw_stable[i] <= sync2[i] and cnt[i] <= 0.
    - On the same edge, sw_rise[i] <= sync2[i] and sw_fall[i] <= ~sync2[i].
  - Else cnt[i] <= cnt[i]+1.
  - Any single cycle where sync2[i] returns to sw_stable[i] restarts the count from 0. Bounces shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a level on sw_in captured at edge E appears on sw_stable at edge E+1+DEBOUNCE_CYCLES (sync2 valid at E+1, then DEBOUNCE_CYCLES mismatched cycles). With DEBOUNCE_CYCLES=1, sw_stable follows sync2 one edge later.
- Pulses:
  - sw_rise and sw_fall are registered. They are high for exactly the one cycle in which sw_stable has just changed, and 0 on every other cycle.
  - sw_rise[i] and sw_fall[i] are never both high.
- Sticky flags:
  - chg_sticky[i] <= 1 on any edge where sw_stable[i] changes (the same edge as the pulse).
  - Otherwise chg_sticky[i] <= 0 if chg_clr[i] is high.
  - Otherwise chg_sticky[i] holds.
  - Set wins over a simultaneous clear.
- irq: combinational OR of (chg_sticky & irq_en) taken from registered signals. It stays high until software clears the flag or masks it.
- Post-reset: a switch held high through reset produces a normal rise event (pulse plus sticky) DEBOUNCE_CYCLES+2 cycles after reset deasserts. This is intended, and software clears it at boot.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Simultaneous changes on different switches are processed independently and may pulse in the same cycle.

Test Plan (bench uses DEBOUNCE_CYCLES=8, NUM_SW=2):
- Reset with sw_in=00, irq_en=11, held 30 cycles → sw_stable=00, sw_rise=sw_fall=chg_sticky=00, irq=0 throughout.
- sw_in[0] 0→1 sampled at edge E and held → sw_stable[0]=1 from edge E+9. sw_rise[0]=1 for that single cycle only. chg_sticky=01 and irq=1 from E+9. sw_fall stays 00.
- Bounce on sw_in[1]: high 5 cycles, low 3, high 4, then high steady → no change on sw_stable[1] and no pulses during the bounce. Single sw_rise[1] pulse 9 edges after the final rising sample.
- With chg_sticky=01, assert chg_clr=01 for one cycle → chg_sticky=00 and irq=0 next edge. Repeat with chg_clr[0] high on the same edge as an sw_fall[0] event → chg_sticky[0] remains 1.
- sw_in 00→11 in one cycle → sw_rise=11 in the same single cycle, sw_stable=11. Then irq_en=10 with chg_clr=10 → irq=0 while chg_sticky=01.
- sw_in[0] raised, then s_axi_areset pulsed at count 5 → sw_stable=0, no pulse. With the input still high, a full 8-cycle count after reset release is required before sw_rise[0] fires.
